// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
// Shared defaults and helpers for the input conditioner.
//   INPUT_COND_WIDTH    default number of channels
//   INPUT_COND_DEBOUNCE default number of stable cycles before a level change
//   INPUT_COND_CNT_W    default width of the rising-edge event counter
//   dc_width()          width of the per-channel debounce counter
//   chan_out_t          registered outputs of one channel
// -----------------------------------------------------------------------------
package input_cond_pkg;

   localparam int INPUT_COND_WIDTH    = 8;
   localparam int INPUT_COND_DEBOUNCE = 4;
   localparam int INPUT_COND_CNT_W    = 8;

   // The debounce counter only has to reach DEBOUNCE_CYCLES-1, but it must be at
   // least one bit wide so that DEBOUNCE_CYCLES of 1 or 2 still builds.
   function automatic int dc_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

   typedef struct packed {
      logic dout;
      logic rise;
      logic fall;
   } chan_out_t;

endpackage

// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_cond_if
// Bundles the conditioner's data and control signals.
//   master modport: drives ena, din, invert, cnt_sel, cnt_clr;
//                   observes dout, rise, fall, cnt_value, cnt_ovf
//   slave modport : the conditioner itself (mirror image of master)
// WIDTH and CNT_W must match the parameters of the attached conditioner.
// -----------------------------------------------------------------------------
interface input_cond_if
   import input_cond_pkg::*;
#(
   parameter int WIDTH = INPUT_COND_WIDTH,
   parameter int CNT_W = INPUT_COND_CNT_W
);
   logic             ena;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] invert;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [2:0]       cnt_sel;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_ovf;

   modport master (
      output ena, din, invert, cnt_sel, cnt_clr,
      input  dout, rise, fall, cnt_value, cnt_ovf
   );

   modport slave (
      input  ena, din, invert, cnt_sel, cnt_clr,
      output dout, rise, fall, cnt_value, cnt_ovf
   );
endinterface

// File: rtl/input_conditioner_chan.sv
// -----------------------------------------------------------------------------
// input_cond_chan
// One conditioner channel: 2-flop synchroniser, debounce filter, run-time
// polarity select and registered edge detection.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ena_i    1 = debounce/output advance; 0 = hold, edge pulses forced low
//   din_i    raw asynchronous pad input
//   invert_i 1 = output is the inverted debounced level
//   out_o    registered dout / rise / fall
// -----------------------------------------------------------------------------
module input_cond_chan
   import input_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = INPUT_COND_DEBOUNCE
)(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      ena_i,
   input  logic      din_i,
   input  logic      invert_i,
   output chan_out_t out_o
);

   localparam int              DC_W    = dc_width(DEBOUNCE_CYCLES);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

   logic            s1_q, s2_q;
   logic            stable_q, stable_d;
   logic [DC_W-1:0] dc_q, dc_d;
   logic            dout_q, dout_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic            level;

   // Synchroniser runs regardless of ena so no stale sample is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= din_i;
         s2_q <= s1_q;
      end
   end

   // Debounce: the synchronised level must disagree with stable for
   // DEBOUNCE_CYCLES consecutive enabled cycles before it is adopted.
   always_comb begin
      stable_d = stable_q;
      dc_d     = dc_q;
      if (ena_i) begin
         if (s2_q == stable_q) begin
            dc_d = '0;
         end else if (dc_q == DC_LAST) begin
            stable_d = s2_q;
            dc_d     = '0;
         end else begin
            dc_d = dc_q + DC_W'(1);
         end
      end
   end

   assign level = stable_q ^ invert_i;

   // Edges are measured against the registered output, so an invert toggle
   // also produces a pulse.
   always_comb begin
      dout_d = ena_i ? level : dout_q;
      rise_d = ena_i &  level & ~dout_q;
      fall_d = ena_i & ~level &  dout_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= 1'b0;
         dc_q     <= '0;
         dout_q   <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         dc_q     <= dc_d;
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign out_o = '{dout: dout_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// WIDTH-channel input conditioner with an optional rising-edge event counter.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus_io  input_cond_if.slave:
//             ena, din, invert, cnt_sel, cnt_clr (in)
//             dout, rise, fall, cnt_value, cnt_ovf (out, registered)
// Build option: define INPUT_COND_EDGE_CNT_EN to include the saturating counter
// of rise[cnt_sel]; otherwise cnt_value/cnt_ovf read 0 and no counter exists.
// -----------------------------------------------------------------------------
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int WIDTH           = INPUT_COND_WIDTH,
   parameter int DEBOUNCE_CYCLES = INPUT_COND_DEBOUNCE,
   parameter int CNT_W           = INPUT_COND_CNT_W
)(
   input logic        clk,
   input logic        rst_n,
   input_cond_if.slave bus_io
);

   logic [WIDTH-1:0] dout_w, rise_w, fall_w;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         chan_out_t chan_out;

         input_cond_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena_i    (bus_io.ena),
            .din_i    (bus_io.din[gi]),
            .invert_i (bus_io.invert[gi]),
            .out_o    (chan_out)
         );

         assign dout_w[gi] = chan_out.dout;
         assign rise_w[gi] = chan_out.rise;
         assign fall_w[gi] = chan_out.fall;
      end
   endgenerate

   assign bus_io.dout = dout_w;
   assign bus_io.rise = rise_w;
   assign bus_io.fall = fall_w;

`ifdef INPUT_COND_EDGE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       rise_ext;
   logic             sel_hit;

   // Zero-extending to the full 3-bit select range makes cnt_sel >= WIDTH
   // land on a constant 0, so unimplemented channels never count.
   assign rise_ext = 8'(rise_w);
   assign sel_hit  = rise_ext[bus_io.cnt_sel];

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (bus_io.cnt_clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (bus_io.ena && sel_hit) begin
         if (&cnt_q) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus_io.cnt_value = cnt_q;
   assign bus_io.cnt_ovf   = ovf_q;
`else
   wire cnt_inputs_unused = &{1'b0, bus_io.cnt_sel, bus_io.cnt_clr};

   assign bus_io.cnt_value = '0;
   assign bus_io.cnt_ovf   = 1'b0;
`endif

endmodule
